// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel, the valid/ready
// instruction channel towards the datapath, and the redirect input.
//   master : the fetch unit (drives oIMemReq/oIMemAddr, oInst*, oMisaligned)
//   slave  : memory + datapath side (drives iIMemAck/iIMemData, iInstReady, iRedirect*)
interface instr_fetch_unit_if;
  logic        oIMemReq;
  logic [31:0] oIMemAddr;
  logic        iIMemAck;
  logic [31:0] iIMemData;
  logic [31:0] oInst;
  logic [31:0] oInstPC;
  logic        oInstValid;
  logic        iInstReady;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oMisaligned;

  modport master (
    output oIMemReq, oIMemAddr, oInst, oInstPC, oInstValid, oMisaligned,
    input  iIMemAck, iIMemData, iInstReady, iRedirect, iRedirectPC
  );

  modport slave (
    input  oIMemReq, oIMemAddr, oInst, oInstPC, oInstValid, oMisaligned,
    output iIMemAck, iIMemData, iInstReady, iRedirect, iRedirectPC
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one word request at a
// time to instruction memory (variable-latency req/ack), buffers returned
// words with their PCs in a QDEPTH-entry FIFO and presents the head to the
// datapath over valid/ready. A redirect flushes the FIFO and retargets fetch;
// a request already in flight at redirect time is drained and its data dropped.
// Ports:
//   iClk  - clock, rising edge
//   iClr  - asynchronous reset, active-high
//   bus   - instr_fetch_unit_if.master (memory, instruction and redirect channels)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                  iClk,
  input  logic                  iClr,
  instr_fetch_unit_if.master    bus
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            mis_q, mis_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     inst_q [QDEPTH];
  logic [31:0]     ipc_q  [QDEPTH];

  logic            ack, push, pop;
  logic [CW-1:0]   cnt_after;

  // Ack is only meaningful while a request is up.
  assign ack = (state_q != S_IDLE) && bus.iIMemAck;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    mis_d     = mis_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    pop       = (cnt_q != '0) && bus.iInstReady;
    cnt_after = cnt_q;

    if (bus.iRedirect) begin
      // Flush wins over any same-cycle pop or push.
      pc_d  = bus.iRedirectPC;
      mis_d = (bus.iRedirectPC[1:0] != 2'b00);
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      unique case (state_q)
        S_WAIT:  state_d = ack ? S_IDLE : S_DROP;
        S_DROP:  state_d = ack ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Issuing reserves a FIFO slot, so only go when one is free now.
          if ((cnt_q < CW'(QDEPTH)) && !mis_q) begin
            state_d = S_WAIT;
            addr_d  = pc_q;
          end
        end
        S_WAIT: begin
          if (ack) begin
            push      = 1'b1;
            pc_d      = pc_q + 32'd4;
            cnt_after = cnt_q + CW'(1) - CW'(pop);
            // Back-to-back issue when a slot is still free after this cycle.
            if (cnt_after < CW'(QDEPTH)) addr_d = pc_q + 32'd4;
            else                         state_d = S_IDLE;
          end
        end
        S_DROP: begin
          if (ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (pop)  rd_d = rd_q + AW'(1);
      if (push) wr_d = wr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge iClk or posedge iClr) begin
    if (iClr) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      mis_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge iClk or posedge iClr) begin
    if (iClr) begin
      for (int i = 0; i < QDEPTH; i++) begin
        inst_q[i] <= '0;
        ipc_q[i]  <= '0;
      end
    end else if (push) begin
      inst_q[wr_q] <= bus.iIMemData;
      ipc_q[wr_q]  <= addr_q;
    end
  end

  assign bus.oIMemReq    = (state_q != S_IDLE);
  assign bus.oIMemAddr   = addr_q;
  assign bus.oInst       = inst_q[rd_q];
  assign bus.oInstPC     = ipc_q[rd_q];
  assign bus.oInstValid  = (cnt_q != '0);
  assign bus.oMisaligned = mis_q;
endmodule
